td4_sequencer: RTL and testbench
================================

Name: td4_sequencer

Overview:
Run-control and program-store block for the 4-bit TD4 CPU core.
- Holds a 16x8 program memory loaded over a valid/ready command port.
- Presents {opcode, immediate} for the CPU's current PC.
- Drives the CPU's clock enable (cpu_en) and its synchronous restart (cpu_rst_n).
- Supports run, single-step, halt/restart and a hardware breakpoint.
- Sits between the top-level IO pins and the CPU core; the CPU advances PC/registers only on edges where cpu_en=1.

Parameters:
CNT_W, 8, width of the executed-instruction counter (saturating)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted on a cycle where cmd_valid&cmd_ready
cmd  in  2  00 WRITE, 01 RUN, 10 STEP, 11 HALT
wr_addr  in  4  program address for WRITE
wr_data  in  8  program word for WRITE: [7:4] opcode, [3:0] immediate
brk_en  in  1  breakpoint enable
brk_addr  in  4  breakpoint PC
pc_in  in  4  current PC from CPU
opcode  out  4  mem[pc_in][7:4]
immediate  out  4  mem[pc_in][3:0]
cpu_en  out  1  CPU clock enable
cpu_rst_n  out  1  CPU restart, active-low, one-cycle pulse
state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 BREAK
step_done  out  1  one-cycle pulse after each STEP or breakpoint stop
instr_cnt  out  CNT_W  count of cpu_en cycles since last restart

Behaviour:
Reset (rst_n=0):
- state=IDLE, cpu_en=0, cpu_rst_n=0, step_done=0, instr_cnt=0, skip=0.
- All memory words = 8'h00 (ADD A,0, i.e. a NOP).
- cpu_rst_n rises to 1 on the first clk edge after rst_n deasserts.

Memory:
- Asynchronous read: opcode/immediate follow pc_in combinationally.
- Write is synchronous on an accepted WRITE.

cmd_ready:
- 1 in IDLE, RUN and BREAK; 0 in STEP.
- Must not depend combinationally on cmd_valid.

IDLE:
- cpu_en=0.
- WRITE: mem[wr_addr]<=wr_data.
- RUN: go to RUN.
- STEP: go to STEP.
- HALT: cpu_rst_n=0 for exactly the next cycle, instr_cnt<=0; stay IDLE.

RUN:
- cpu_en=1 every cycle, except when brk_en && pc_in==brk_addr && !skip. In that case cpu_en=0, the next state is BREAK and step_done pulses on the next cycle.
- skip clears after the first RUN cycle.
- HALT: go to IDLE, with cpu_en=0 in that same cycle.
- WRITE, RUN and STEP are accepted and ignored; memory is not modified while running.
- Simultaneous HALT and breakpoint match: HALT wins, go to IDLE, no step_done.

STEP:
- Exactly one cycle with cpu_en=1, then return to the state STEP was entered from (IDLE or BREAK).
- step_done=1 in the following cycle.
- The breakpoint is ignored during STEP.

BREAK:
- cpu_en=0; command handling is the same as IDLE.
- RUN from BREAK sets skip=1, so the breakpoint instruction itself executes.
- HALT goes to IDLE and restarts the CPU.

instr_cnt:
- Increments on every cycle with cpu_en=1.
- Saturates at 2^CNT_W-1.
- Cleared only by rst_n or HALT.

Edges and boundaries:
- PC wrap 15->0 is the CPU's concern; the breakpoint compare is pure equality, so brk_addr=0 matches after wrap.
- Asynchronous reset mid-RUN or mid-STEP returns everything to the reset values immediately; memory contents are cleared.

Decomposition:
- Package td4_pkg:
  - Command encodings CMD_WRITE/RUN/STEP/HALT.
  - State encoding typedef (2-bit) S_IDLE/S_RUN/S_STEP/S_BREAK.
  - Constant PROG_DEPTH=16.
- Sub-module td4_prog_mem: 16x8 flop array with async-reset clear, one synchronous write port and one asynchronous read port.
- The FSM, counter and breakpoint logic live in td4_sequencer.

Test Plan:
1. Reset, then WRITE addr3=8'hC5 -> one cycle later with pc_in=3: opcode=4'hC, immediate=4'h5; state=IDLE, cpu_en=0.
2. RUN, then HALT after 10 cycles -> cpu_en high exactly 10 cycles, instr_cnt=10, state=IDLE; a second HALT gives cpu_rst_n low one cycle and instr_cnt=0.
3. brk_en=1, brk_addr=4, RUN with the CPU counting up from pc 0 -> cpu_en=0 when pc_in=4, state=BREAK, step_done pulse, instr_cnt=4; RUN again -> cpu_en=1 at pc 4, run continues.
4. STEP from IDLE three times -> each gives a one-cycle cpu_en, step_done one cycle later, cmd_ready=0 during STEP, instr_cnt=3.
5. During RUN, WRITE addr0=8'hFF -> memory unchanged (addr0 still reads 8'h00); HALT on the same cycle as a breakpoint match -> IDLE, no step_done.
6. Assert rst_n low mid-RUN with instr_cnt=200 -> cpu_en=0, instr_cnt=0, memory reads 0 immediately; run to 300 cycles with CNT_W=8 -> instr_cnt holds at 255.

Source files
------------

// File: rtl/td4_pkg.sv
// -----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 run-control / program-store slice:
//   - command encodings on the cmd port
//   - run-control state encoding (also the value driven on the state port)
//   - program memory geometry
// -----------------------------------------------------------------------------
package td4_pkg;

   localparam int PROG_DEPTH = 16;
   localparam int ADDR_W     = 4;
   localparam int WORD_W     = 8;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_STEP  = 2'b10,
      CMD_HALT  = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STEP  = 2'b10,
      S_BREAK = 2'b11
   } state_e;

endpackage

// File: rtl/td4_prog_mem.sv
// -----------------------------------------------------------------------------
// td4_prog_mem
// 16x8 program store built from flops so that it can be cleared by the
// asynchronous reset and read combinationally by the CPU.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset, clears every word to 8'h00
//   we_i     in   write enable (one synchronous write port)
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address (asynchronous read port)
//   rdata_o  out  word at raddr_i
// -----------------------------------------------------------------------------
module td4_prog_mem
   import td4_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [PROG_DEPTH-1:0][WORD_W-1:0] mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4_sequencer.sv
// -----------------------------------------------------------------------------
// td4_sequencer
// Run-control and program store for the TD4 CPU core. Loads the program over
// a valid/ready command port, presents {opcode, immediate} for the CPU's PC,
// and gates the CPU with cpu_en / cpu_rst_n for run, single-step, halt and a
// hardware breakpoint.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready depends on state only)
//   cmd                  00 WRITE, 01 RUN, 10 STEP, 11 HALT
//   wr_addr, wr_data     program address / word for WRITE
//   brk_en, brk_addr     hardware breakpoint
//   pc_in                CPU program counter
//   opcode, immediate    mem[pc_in][7:4], mem[pc_in][3:0]
//   cpu_en               CPU clock enable
//   cpu_rst_n            CPU restart, one-cycle low pulse
//   state                00 IDLE, 01 RUN, 10 STEP, 11 BREAK
//   step_done            pulse after each STEP or breakpoint stop
//   instr_cnt            saturating count of cpu_en cycles since restart
// -----------------------------------------------------------------------------
module td4_sequencer
   import td4_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd,
   input  logic [3:0]       wr_addr,
   input  logic [7:0]       wr_data,
   input  logic             brk_en,
   input  logic [3:0]       brk_addr,
   input  logic [3:0]       pc_in,
   output logic [3:0]       opcode,
   output logic [3:0]       immediate,
   output logic             cpu_en,
   output logic             cpu_rst_n,
   output logic [1:0]       state,
   output logic             step_done,
   output logic [CNT_W-1:0] instr_cnt
);

   state_e           state_q, state_d;
   logic             from_brk_q, from_brk_d;   // STEP returns to BREAK when set
   logic             skip_q, skip_d;           // lets the breakpoint instruction run once
   logic             step_done_q, step_done_d;
   logic             cpu_rst_n_q, cpu_rst_n_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             en;
   logic             cnt_clr;
   logic             mem_we;
   logic             cmd_acc;
   logic             write_acc, run_acc, step_acc, halt_acc;
   logic             brk_hit;
   logic [7:0]       rd_word;

   td4_prog_mem u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (mem_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (pc_in),
      .rdata_o (rd_word)
   );

   assign opcode    = rd_word[7:4];
   assign immediate = rd_word[3:0];

   // Only STEP refuses commands, so the CPU gets its single enabled cycle
   // without interference.
   assign cmd_ready = (state_q != S_STEP);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign write_acc = cmd_acc && (cmd == CMD_WRITE);
   assign run_acc   = cmd_acc && (cmd == CMD_RUN);
   assign step_acc  = cmd_acc && (cmd == CMD_STEP);
   assign halt_acc  = cmd_acc && (cmd == CMD_HALT);
   assign brk_hit   = brk_en && (pc_in == brk_addr) && !skip_q;

   always_comb begin
      state_d     = state_q;
      from_brk_d  = from_brk_q;
      skip_d      = skip_q;
      step_done_d = 1'b0;
      cpu_rst_n_d = 1'b1;
      en          = 1'b0;
      cnt_clr     = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         S_IDLE, S_BREAK: begin
            mem_we = write_acc;
            if (run_acc) begin
               state_d = S_RUN;
               skip_d  = (state_q == S_BREAK);
            end else if (step_acc) begin
               state_d    = S_STEP;
               from_brk_d = (state_q == S_BREAK);
            end else if (halt_acc) begin
               state_d     = S_IDLE;
               cpu_rst_n_d = 1'b0;
               cnt_clr     = 1'b1;
            end
         end
         S_RUN: begin
            skip_d = 1'b0;
            // HALT takes priority over a breakpoint match in the same cycle.
            if (halt_acc) begin
               state_d = S_IDLE;
            end else if (brk_hit) begin
               state_d     = S_BREAK;
               step_done_d = 1'b1;
            end else begin
               en = 1'b1;
            end
         end
         S_STEP: begin
            en          = 1'b1;
            step_done_d = 1'b1;
            state_d     = from_brk_q ? S_BREAK : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         from_brk_q  <= 1'b0;
         skip_q      <= 1'b0;
         step_done_q <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         from_brk_q  <= from_brk_d;
         skip_q      <= skip_d;
         step_done_q <= step_done_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cpu_en    = en;
   assign cpu_rst_n = cpu_rst_n_q;
   assign state     = state_q;
   assign step_done = step_done_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// -----------------------------------------------------------------------------
// tb_td4_sequencer
// Directed scenarios with hand-computed expectations followed by randomized
// commands, all compared every cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_td4_sequencer;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd;
   logic [3:0]       wr_addr;
   logic [7:0]       wr_data;
   logic             brk_en;
   logic [3:0]       brk_addr;
   logic [3:0]       pc_in;
   logic [3:0]       opcode;
   logic [3:0]       immediate;
   logic             cpu_en;
   logic             cpu_rst_n;
   logic [1:0]       state;
   logic             step_done;
   logic [CNT_W-1:0] instr_cnt;

   always #5 clk = ~clk;

   td4_sequencer #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .brk_en    (brk_en),
      .brk_addr  (brk_addr),
      .pc_in     (pc_in),
      .opcode    (opcode),
      .immediate (immediate),
      .cpu_en    (cpu_en),
      .cpu_rst_n (cpu_rst_n),
      .state     (state),
      .step_done (step_done),
      .instr_cnt (instr_cnt)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: mode 0 idle, 1 running, 2 single-step, 3 stopped at breakpoint
   int        m_mode;
   bit        m_back_brk;
   bit        m_skip;
   bit        m_done;
   bit        m_restart;
   int        m_count;
   logic [7:0] m_mem [16];
   int        cpu_pc;
   bit        follow_pc;

   bit e_ready, e_acc, e_halt, e_stop, e_en;

   task automatic model_reset();
      m_mode     = 0;
      m_back_brk = 0;
      m_skip     = 0;
      m_done     = 0;
      m_restart  = 1;
      m_count    = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      cpu_pc = 0;
   endtask

   task automatic predict();
      e_ready = (m_mode != 2);
      e_acc   = cmd_valid && e_ready;
      e_halt  = e_acc && (cmd == 2'd3);
      e_stop  = brk_en && (pc_in == brk_addr) && !m_skip;
      e_en    = (m_mode == 2) || (m_mode == 1 && !e_halt && !e_stop);
   endtask

   task automatic model_update();
      int nm;
      if (!rst_n) begin
         model_reset();
         return;
      end
      predict();
      // CPU: restart wins, otherwise PC advances on enabled edges
      if (m_restart) cpu_pc = 0;
      else if (e_en) cpu_pc = (cpu_pc + 1) % 16;
      nm = m_mode;
      if (m_mode == 0 || m_mode == 3) begin
         if (e_acc) begin
            case (cmd)
               2'd0: m_mem[wr_addr] = wr_data;
               2'd1: begin nm = 1; m_skip = (m_mode == 3); end
               2'd2: begin nm = 2; m_back_brk = (m_mode == 3); end
               default: nm = 0;
            endcase
         end
      end else if (m_mode == 1) begin
         if (e_halt) nm = 0;
         else if (e_stop) nm = 3;
         m_skip = 0;
      end else begin
         nm = m_back_brk ? 3 : 0;
      end
      m_done    = (m_mode == 2) || (m_mode == 1 && !e_halt && e_stop);
      m_restart = e_halt && (m_mode != 1);
      if (m_restart) m_count = 0;
      else if (e_en && m_count < CNT_MAX) m_count = m_count + 1;
      m_mode = nm;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      predict();
      chk("state",     32'(state),     32'(m_mode));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("cpu_en",    32'(cpu_en),    32'(e_en));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(!m_restart));
      chk("step_done", 32'(step_done), 32'(m_done));
      chk("instr_cnt", 32'(instr_cnt), 32'(m_count));
      chk("opcode",    32'(opcode),    32'(m_mem[pc_in][7:4]));
      chk("immediate", 32'(immediate), 32'(m_mem[pc_in][3:0]));
   endtask

   task automatic sample();
      @(negedge clk);
      compare_all();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #2;
      if (follow_pc) pc_in = 4'(cpu_pc);
   endtask

   task automatic cycle();
      sample();
      adv();
   endtask

   task automatic send(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd       = c;
      cycle();
      cmd_valid = 1'b0;
   endtask

   int en_seen;
   int r;

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd       = 2'd0;
      wr_addr   = 4'd0;
      wr_data   = 8'd0;
      brk_en    = 1'b0;
      brk_addr  = 4'd0;
      pc_in     = 4'd0;
      follow_pc = 1;
      model_reset();

      // Reset values
      sample();
      chk("rst_state", 32'(state), 0);
      chk("rst_cpu_en", 32'(cpu_en), 0);
      chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
      chk("rst_instr_cnt", 32'(instr_cnt), 0);
      chk("rst_step_done", 32'(step_done), 0);
      adv();
      rst_n = 1'b1;
      sample();
      chk("cpu_rst_n_before_edge", 32'(cpu_rst_n), 0);
      adv();

      // 1: program write then read back through pc_in
      cmd_valid = 1'b1; cmd = 2'd0; wr_addr = 4'd3; wr_data = 8'hC5;
      sample();
      chk("cpu_rst_n_after_edge", 32'(cpu_rst_n), 1);
      adv();
      cmd_valid = 1'b0;
      follow_pc = 0; pc_in = 4'd3;
      sample();
      chk("t1_opcode", 32'(opcode), 32'hC);
      chk("t1_immediate", 32'(immediate), 32'h5);
      chk("t1_state", 32'(state), 0);
      chk("t1_cpu_en", 32'(cpu_en), 0);
      adv();

      // 2: run for ten cycles then halt
      follow_pc = 1; pc_in = 4'(cpu_pc);
      send(2'd1);
      en_seen = 0;
      repeat (10) begin
         sample();
         en_seen += int'(cpu_en);
         adv();
      end
      cmd_valid = 1'b1; cmd = 2'd3;
      sample();
      chk("t2_halt_cycle_en", 32'(cpu_en), 0);
      adv();
      cmd_valid = 1'b0;
      sample();
      chk("t2_en_cycles", 32'(en_seen), 10);
      chk("t2_instr_cnt", 32'(instr_cnt), 10);
      chk("t2_state", 32'(state), 0);
      adv();
      send(2'd3);
      sample();
      chk("t2_restart_pulse", 32'(cpu_rst_n), 0);
      chk("t2_cnt_cleared", 32'(instr_cnt), 0);
      adv();
      sample();
      chk("t2_restart_end", 32'(cpu_rst_n), 1);
      adv();

      // 3: breakpoint at pc 4, then resume over it
      brk_en = 1'b1; brk_addr = 4'd4;
      send(2'd1);
      repeat (4) cycle();
      sample();
      chk("t3_pc_at_brk", 32'(pc_in), 4);
      chk("t3_brk_en_low", 32'(cpu_en), 0);
      adv();
      sample();
      chk("t3_state_break", 32'(state), 3);
      chk("t3_step_done", 32'(step_done), 1);
      chk("t3_instr_cnt", 32'(instr_cnt), 4);
      adv();
      sample();
      chk("t3_step_done_pulse", 32'(step_done), 0);
      adv();
      send(2'd1);
      sample();
      chk("t3_resume_state", 32'(state), 1);
      chk("t3_resume_en", 32'(cpu_en), 1);
      adv();
      sample();
      chk("t3_continue_en", 32'(cpu_en), 1);
      adv();
      cmd_valid = 1'b1; cmd = 2'd3;
      cycle();
      cycle();
      cmd_valid = 1'b0;
      brk_en = 1'b0;
      cycle();

      // 4: three single steps from IDLE
      repeat (3) begin
         cmd_valid = 1'b1; cmd = 2'd2;
         sample();
         chk("t4_ready_idle", 32'(cmd_ready), 1);
         adv();
         cmd_valid = 1'b0;
         sample();
         chk("t4_state_step", 32'(state), 2);
         chk("t4_ready_step", 32'(cmd_ready), 0);
         chk("t4_en_step", 32'(cpu_en), 1);
         adv();
         sample();
         chk("t4_back_idle", 32'(state), 0);
         chk("t4_step_done", 32'(step_done), 1);
         adv();
      end
      sample();
      chk("t4_instr_cnt", 32'(instr_cnt), 3);
      adv();

      // 5: write ignored while running; HALT beats a breakpoint match
      send(2'd1);
      cmd_valid = 1'b1; cmd = 2'd0; wr_addr = 4'd0; wr_data = 8'hFF;
      cycle();
      cmd_valid = 1'b0;
      follow_pc = 0; pc_in = 4'd0;
      sample();
      chk("t5_mem0_op", 32'(opcode), 0);
      chk("t5_mem0_imm", 32'(immediate), 0);
      adv();
      pc_in = 4'd7; brk_en = 1'b1; brk_addr = 4'd7;
      cmd_valid = 1'b1; cmd = 2'd3;
      sample();
      chk("t5_halt_brk_en", 32'(cpu_en), 0);
      adv();
      cmd_valid = 1'b0; brk_en = 1'b0;
      sample();
      chk("t5_halt_brk_state", 32'(state), 0);
      chk("t5_halt_brk_done", 32'(step_done), 0);
      adv();

      // 6: async reset mid-run, then counter saturation
      send(2'd3);
      pc_in = 4'd3;
      send(2'd1);
      repeat (200) cycle();
      sample();
      chk("t6_cnt_200", 32'(instr_cnt), 200);
      chk("t6_pre_reset_op", 32'(opcode), 32'hC);
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("t6_rst_en", 32'(cpu_en), 0);
      chk("t6_rst_cnt", 32'(instr_cnt), 0);
      chk("t6_rst_mem", 32'(opcode), 0);
      adv();
      rst_n = 1'b1;
      cycle();
      send(2'd1);
      repeat (300) cycle();
      sample();
      chk("t6_saturated", 32'(instr_cnt), 255);
      adv();
      send(2'd3);
      send(2'd3);

      // Randomized traffic against the model
      follow_pc = 1;
      for (int i = 0; i < 3000; i++) begin
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end
         cmd_valid = ($urandom_range(0, 3) == 0);
         r = int'($urandom_range(0, 15));
         cmd = (r < 5) ? 2'd0 : (r < 9) ? 2'd1 : (r < 13) ? 2'd2 : 2'd3;
         wr_addr = 4'($urandom);
         wr_data = 8'($urandom);
         if ($urandom_range(0, 15) == 0) brk_addr = 4'($urandom);
         if ($urandom_range(0, 7) == 0) brk_en = ~brk_en;
         if ($urandom_range(0, 31) == 0) follow_pc = ~follow_pc;
         pc_in = follow_pc ? 4'(cpu_pc) : 4'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
